sr_button_ctrl: RTL and testbench

Upstream command stage for the sr_ff flip-flop. Takes two raw push-button inputs (set, reset) and synchronizes and debounces each one. It then turns debounced presses into single-cycle, mutually exclusive S/R pulses that drive the flip-flop's S and R inputs on the same clk. Simultaneous or overlapping presses never produce S and R together; they are flagged on a conflict pulse instead.

---
 rtl/sr_ctrl_pkg.sv | 14 +
 rtl/debounce_sync.sv | 51 +++++
 rtl/sr_button_ctrl.sv | 126 ++++++++++++
 tb/tb_sr_button_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the sr_ff button command stage.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SET_ACT = 2'd1,
      RST_ACT = 2'd2,
      LOCK    = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability counter; db follows the
// synchronized level once it has differed from db for DEBOUNCE_CYCLES-1 edges.
module debounce_sync
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_db;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // The edge whose increment reaches the last count is the one that commits,
   // so a level stable from sample edge N lands on db at edge N+DEBOUNCE_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_db) begin
            if (w_cnt_inc == LP_CNT_LAST) begin
               r_db  <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign db = r_db;

endmodule

// File: rtl/sr_button_ctrl.sv
// Debounced set/reset buttons turned into one-cycle, mutually exclusive S/R
// pulses for sr_ff; overlapping presses raise a conflict pulse instead.
module sr_button_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set_raw,
   input  logic btn_reset_raw,
   output logic S,
   output logic R,
   output logic conflict,
   output logic db_set,
   output logic db_reset
);

   logic   w_db_set;
   logic   w_db_reset;
   logic   r_db_set_d;
   logic   r_db_reset_d;
   logic   w_rise_set;
   logic   w_rise_reset;
   state_t r_state;
   logic   r_s;
   logic   r_r;
   logic   r_conflict;

   debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_db_set (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_set_raw),
      .db   (w_db_set)
   );

   debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_db_reset (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_reset_raw),
      .db   (w_db_reset)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_set_d   <= 1'b0;
         r_db_reset_d <= 1'b0;
      end else begin
         r_db_set_d   <= w_db_set;
         r_db_reset_d <= w_db_reset;
      end
   end

   assign w_rise_set   = w_db_set   & ~r_db_set_d;
   assign w_rise_reset = w_db_reset & ~r_db_reset_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise_set && w_rise_reset) begin
                  r_conflict <= 1'b1;
                  r_state    <= LOCK;
               end else if (w_rise_set) begin
                  r_s     <= 1'b1;
                  r_state <= SET_ACT;
               end else if (w_rise_reset) begin
                  r_r     <= 1'b1;
                  r_state <= RST_ACT;
               end
            end
            SET_ACT: begin
               // A reset rising exactly as set drops is a clean handover.
               if (w_rise_reset && w_db_set) begin
                  r_conflict <= 1'b1;
                  r_state    <= LOCK;
               end else if (w_rise_reset) begin
                  r_r     <= 1'b1;
                  r_state <= RST_ACT;
               end else if (!w_db_set && !w_db_reset) begin
                  r_state <= IDLE;
               end
            end
            RST_ACT: begin
               if (w_rise_set && w_db_reset) begin
                  r_conflict <= 1'b1;
                  r_state    <= LOCK;
               end else if (w_rise_set) begin
                  r_s     <= 1'b1;
                  r_state <= SET_ACT;
               end else if (!w_db_set && !w_db_reset) begin
                  r_state <= IDLE;
               end
            end
            LOCK: begin
               if (!w_db_set && !w_db_reset) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign S        = r_s;
   assign R        = r_r;
   assign conflict = r_conflict;
   assign db_set   = w_db_set;
   assign db_reset = w_db_reset;

endmodule

// File: tb/tb_sr_button_ctrl.sv
// Directed bench for sr_button_ctrl with DEBOUNCE_CYCLES=4.
module tb_sr_button_ctrl;

   localparam int DC = 4;

   logic clk           = 1'b0;
   logic rst_n         = 1'b0;
   logic btn_set_raw   = 1'b0;
   logic btn_reset_raw = 1'b0;
   logic S;
   logic R;
   logic conflict;
   logic db_set;
   logic db_reset;

   int n_pass   = 0;
   int n_checks = 0;
   int cnt_s    = 0;
   int cnt_r    = 0;
   int cnt_c    = 0;
   int cnt_dbs  = 0;
   int excl_bad = 0;

   always #5 clk = ~clk;

   sr_button_ctrl #(
      .DEBOUNCE_CYCLES(DC),
      .CNT_W          (20)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_set_raw  (btn_set_raw),
      .btn_reset_raw(btn_reset_raw),
      .S            (S),
      .R            (R),
      .conflict     (conflict),
      .db_set       (db_set),
      .db_reset     (db_reset)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance n clock edges, sampling 1 time unit after each, and tally pulses.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (S === 1'b1)        cnt_s++;
         if (R === 1'b1)        cnt_r++;
         if (conflict === 1'b1) cnt_c++;
         if (db_set === 1'b1)   cnt_dbs++;
         if (int'(S === 1'b1) + int'(R === 1'b1) + int'(conflict === 1'b1) > 1) excl_bad++;
      end
   endtask

   task automatic clr();
      cnt_s   = 0;
      cnt_r   = 0;
      cnt_c   = 0;
      cnt_dbs = 0;
   endtask

   function automatic logic [31:0] outs();
      return {27'd0, S, R, conflict, db_set, db_reset};
   endfunction

   initial begin
      // Reset state, before and after an edge with rst_n held low
      #12;
      check("rst_outs_noedge", outs(), 32'd0);
      step(1);
      check("rst_outs_edge", outs(), 32'd0);
      rst_n = 1'b1;
      step(3);
      check("idle_outs", outs(), 32'd0);

      // 1. Clean set press
      clr();
      btn_set_raw = 1'b1;
      step(DC);
      check("s1_db_early", {31'd0, db_set}, 32'd0);
      step(1);
      check("s1_db_rise", {31'd0, db_set}, 32'd1);
      check("s1_s_before", {31'd0, S}, 32'd0);
      step(1);
      check("s1_s_pulse", {29'd0, S, R, conflict}, 32'd4);
      step(1);
      check("s1_s_after", {31'd0, S}, 32'd0);
      step(5);
      btn_set_raw = 1'b0;
      step(10);
      check("s1_cnt_s", cnt_s, 1);
      check("s1_cnt_rc", cnt_r + cnt_c, 0);
      check("s1_db_released", {31'd0, db_set}, 32'd0);

      // 2. Bounce rejection, then a clean hold
      clr();
      btn_set_raw = 1'b1; step(2);
      btn_set_raw = 1'b0; step(1);
      btn_set_raw = 1'b1; step(2);
      btn_set_raw = 1'b0; step(10);
      check("s2_bounce_db", cnt_dbs, 0);
      check("s2_bounce_s", cnt_s, 0);
      btn_set_raw = 1'b1; step(6);
      btn_set_raw = 1'b0; step(10);
      check("s2_hold_s", cnt_s, 1);
      check("s2_hold_rc", cnt_r + cnt_c, 0);

      // 3. Simultaneous press
      clr();
      btn_set_raw   = 1'b1;
      btn_reset_raw = 1'b1;
      step(DC + 1);
      check("s3_db_both", {30'd0, db_set, db_reset}, 32'd3);
      check("s3_c_before", {31'd0, conflict}, 32'd0);
      step(1);
      check("s3_c_pulse", {29'd0, S, R, conflict}, 32'd1);
      step(1);
      check("s3_c_after", {31'd0, conflict}, 32'd0);
      btn_set_raw   = 1'b0;
      btn_reset_raw = 1'b0;
      step(10);
      check("s3_cnt_c", cnt_c, 1);
      check("s3_cnt_sr", cnt_s + cnt_r, 0);
      clr();
      btn_reset_raw = 1'b1; step(10);
      btn_reset_raw = 1'b0; step(10);
      check("s3_next_r", cnt_r, 1);
      check("s3_next_sc", cnt_s + cnt_c, 0);

      // 4. Overlap while set held
      clr();
      btn_set_raw = 1'b1;   step(10);
      btn_reset_raw = 1'b1; step(10);
      check("s4_overlap_c", cnt_c, 1);
      check("s4_overlap_r", cnt_r, 0);
      check("s4_overlap_s", cnt_s, 1);
      btn_set_raw = 1'b0;   step(10);
      check("s4_lock_release", cnt_s * 100 + cnt_r * 10 + cnt_c, 101);
      btn_reset_raw = 1'b0; step(10);
      btn_reset_raw = 1'b1; step(10);
      check("s4_rearm_r", cnt_r, 1);
      btn_reset_raw = 1'b0; step(10);
      check("s4_final", cnt_s * 100 + cnt_r * 10 + cnt_c, 111);

      // 5. Handover: set falls as reset rises
      clr();
      btn_set_raw = 1'b1; step(10);
      btn_set_raw   = 1'b0;
      btn_reset_raw = 1'b1;
      step(DC + 1);
      check("s5_db_swap", {30'd0, db_set, db_reset}, 32'd1);
      check("s5_r_before", {31'd0, R}, 32'd0);
      step(1);
      check("s5_r_pulse", {29'd0, S, R, conflict}, 32'd2);
      step(8);
      btn_set_raw = 1'b1; step(10);
      check("s5_rst_act_conflict", cnt_c, 1);
      check("s5_counts_sr", cnt_s * 10 + cnt_r, 11);
      btn_set_raw   = 1'b0;
      btn_reset_raw = 1'b0;
      step(10);

      // 6. Asynchronous reset between db rise and S
      clr();
      btn_set_raw = 1'b1;
      step(DC + 1);
      check("s6_db_pre", {31'd0, db_set}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("s6_async_clear", outs(), 32'd0);
      step(2);
      check("s6_held_clear", outs(), 32'd0);
      #3 rst_n = 1'b1;
      clr();
      step(DC + 1);
      check("s6_db_again", {31'd0, db_set}, 32'd1);
      check("s6_s_before", {31'd0, S}, 32'd0);
      step(1);
      check("s6_s_pulse", {29'd0, S, R, conflict}, 32'd4);
      step(5);
      btn_set_raw = 1'b0;
      step(10);
      check("s6_cnt", cnt_s * 100 + cnt_r * 10 + cnt_c, 100);

      check("exclusive_outputs", excl_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
